// File: rtl/seg_to_bcd_capture.sv
// seg_to_bcd_capture: debounces a multiplexed 7-seg scan into a BCD frame; define SEG_BLANK_EN to decode all-off as a blank (4'hA).
module seg_to_bcd_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [2:0]  an,
    output logic [11:0] digits,
    output logic        valid,
    output logic        err,
    output logic        frame_done
);
    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;
    localparam logic [3:0] STB = 4'(STABLE_CYCLES);
    state_t      state, state_nxt;
    logic [9:0]  smp, prv;
    logic [3:0]  cnt, cnt_nxt, cnt_inc, dec;
    logic [2:0]  cap, cap_or, cap_nxt, cap_bit, serr, serr_nxt;
    logic [11:0] sdig, sdig_nxt;
    logic        en_ok, same, capture, pub, dec_err;
    logic [1:0]  slot;
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0001100: decode = 5'h09;
`ifdef SEG_BLANK_EN
            7'b1111111: decode = 5'h0A;
`endif
            default:    decode = 5'h1F;
        endcase
    endfunction
    always_comb begin
        {dec_err, dec} = decode(smp[6:0]);
        en_ok = (smp[9:7] == 3'b110) || (smp[9:7] == 3'b101) || (smp[9:7] == 3'b011);
        slot = (smp[9:7] == 3'b110) ? 2'd0 : (smp[9:7] == 3'b101) ? 2'd1 : 2'd2;
        same = smp == prv;
        cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        state_nxt = state;
        cnt_nxt = cnt;
        capture = 1'b0;
        if (!en_ok) begin
            state_nxt = IDLE;
            cnt_nxt = 4'd0;
        end else if (state == IDLE || !same) begin
            state_nxt = TRACK;
            cnt_nxt = 4'd1;
        end else if (state == TRACK) begin
            cnt_nxt = cnt_inc;
            capture = cnt_inc == STB;
            state_nxt = capture ? HELD : TRACK;
        end
        cap_bit = capture ? (3'b001 << slot) : 3'b000;
        sdig_nxt = sdig;
        serr_nxt = serr;
        for (int i = 0; i < 3; i++) begin
            if (cap_bit[i]) begin
                sdig_nxt[i*4 +: 4] = dec;
                serr_nxt[i] = dec_err;
            end
        end
        cap_or = cap | cap_bit;
        pub = &cap_or;
        cap_nxt = pub ? 3'b000 : cap_or;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= '1;
            prv <= '1;
            state <= IDLE;
            cnt <= 4'd0;
            cap <= 3'b000;
            sdig <= 12'h000;
            serr <= 3'b000;
            digits <= 12'h000;
            valid <= 1'b0;
            err <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            smp <= {an, seg};
            prv <= smp;
            state <= state_nxt;
            cnt <= cnt_nxt;
            cap <= cap_nxt;
            sdig <= sdig_nxt;
            serr <= serr_nxt;
            frame_done <= pub;
            if (pub) begin
                digits <= sdig_nxt;
                err <= |serr_nxt;
                valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_to_bcd_capture.sv
// tb_seg_to_bcd_capture: table-driven frames plus scoreboard of published frames.
module tb_seg_to_bcd_capture;
    logic        clk, rst_n;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic [11:0] digits;
    logic        valid, err, frame_done;
    int checks = 0, errors = 0;
    typedef struct { logic [11:0] d; logic e; } exp_t;
    typedef struct {
        logic [6:0]  su, st, sh;
        int          hold, gap;
        logic [11:0] d;
        logic        e;
        bit          pub;
    } vec_t;
    exp_t        q[$];
    vec_t        tbl[6];
    logic [11:0] exp_d;
    logic        exp_e, exp_v;
    seg_to_bcd_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .digits(digits), .valid(valid), .err(err), .frame_done(frame_done)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (q.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("frame_digits", 32'(digits), 32'(x.d));
                chk("frame_err", 32'(err), 32'(x.e));
                chk("frame_valid", 32'(valid), 1);
            end
        end
    end
    task automatic drive(input logic [2:0] a, input logic [6:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic settle(input string name);
        drive(3'b111, 7'h7F, 3);
        chk(name, q.size(), 0);
        q.delete();
        chk({name, "_valid"}, 32'(valid), 32'(exp_v));
        chk({name, "_digits"}, 32'(digits), 32'(exp_d));
        chk({name, "_err"}, 32'(err), 32'(exp_e));
    endtask
    task automatic expect_frame(input logic [11:0] d, input logic e);
        q.push_back('{d: d, e: e});
        exp_d = d;
        exp_e = e;
        exp_v = 1'b1;
    endtask
    task automatic run_frame(input vec_t v);
        drive(3'b110, v.su, v.hold);
        if (v.gap > 0) drive(3'b111, 7'h7F, v.gap);
        drive(3'b101, v.st, v.hold);
        if (v.gap > 0) drive(3'b111, 7'h7F, v.gap);
        if (v.pub) expect_frame(v.d, v.e);
        drive(3'b011, v.sh, v.hold);
        settle("frame_missing");
    endtask
    task automatic chk_reset();
        chk("rst_digits", 32'(digits), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        tbl[0] = '{su: 7'b1001111, st: 7'b0010010, sh: 7'b0000110, hold: 3, gap: 0, d: 12'h000, e: 1'b0, pub: 1'b0};
        tbl[1] = '{su: 7'b1001111, st: 7'b0010010, sh: 7'b0000110, hold: 4, gap: 0, d: 12'h321, e: 1'b0, pub: 1'b1};
        tbl[2] = '{su: 7'b0000001, st: 7'b1001100, sh: 7'b0100000, hold: 5, gap: 2, d: 12'h640, e: 1'b0, pub: 1'b1};
        tbl[3] = '{su: 7'b1111110, st: 7'b0000000, sh: 7'b0001100, hold: 4, gap: 0, d: 12'h98F, e: 1'b1, pub: 1'b1};
`ifdef SEG_BLANK_EN
        tbl[4] = '{su: 7'b0100100, st: 7'b0001111, sh: 7'b1111111, hold: 4, gap: 0, d: 12'hA75, e: 1'b0, pub: 1'b1};
`else
        tbl[4] = '{su: 7'b0100100, st: 7'b0001111, sh: 7'b1111111, hold: 4, gap: 0, d: 12'hF75, e: 1'b1, pub: 1'b1};
`endif
        tbl[5] = '{su: 7'b0010010, st: 7'b0100100, sh: 7'b0000000, hold: 7, gap: 0, d: 12'h852, e: 1'b0, pub: 1'b1};
        exp_d = 12'h000;
        exp_e = 1'b0;
        exp_v = 1'b0;
        rst_n = 0;
        an = 3'b111;
        seg = 7'h7F;
        #12;
        chk_reset();
        rst_n = 1;
        @(posedge clk);
        #1;
        foreach (tbl[i]) run_frame(tbl[i]);
        // an=000 mid-run must restart the tens count, so 3 more samples are not enough
        drive(3'b110, 7'b0100100, 4);
        drive(3'b101, 7'b0100000, 2);
        drive(3'b000, 7'b0100000, 2);
        drive(3'b101, 7'b0100000, 3);
        drive(3'b011, 7'b0001111, 4);
        settle("restart_early");
        expect_frame(12'h765, 1'b0);
        drive(3'b101, 7'b0100000, 4);
        settle("restart_frame");
        // reset after two captures: old slots must be gone, units overwritten, fresh frame needed
        drive(3'b110, 7'b1001111, 4);
        drive(3'b101, 7'b0010010, 4);
        rst_n = 0;
        #3;
        chk_reset();
        rst_n = 1;
        exp_d = 12'h000;
        exp_e = 1'b0;
        exp_v = 1'b0;
        drive(3'b110, 7'b0001111, 4);
        drive(3'b110, 7'b0000000, 4);
        drive(3'b011, 7'b0100100, 4);
        settle("post_reset_partial");
        expect_frame(12'h538, 1'b0);
        drive(3'b101, 7'b0000110, 4);
        settle("post_reset_frame");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
